alu_seq: RTL

Parametrised, handshaked successor to the team's 8-bit ALU. It keeps the 20-opcode operation set and adds opcode 20, an unsigned multi-cycle shift-add multiply.
- Operands are accepted with a valid/ready handshake.
- Results, including a double-width product, are held in an output register until the consumer accepts them.
- Flags follow conventional two's-complement and unsigned carry/borrow rules.
- The block sits between the instruction decode/operand fetch stage and register writeback.

---
 rtl/alu_seq.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Handshaked ALU with registered results/flags and a multi-cycle unsigned
// shift-add multiply that returns a double-width product.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] operand_A,
    input  logic [WIDTH-1:0] operand_B,
    input  logic             carry_in,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_out,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry_out,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             illegal
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    localparam logic [4:0] OP_ADD   = 5'd0,  OP_CADD  = 5'd1,  OP_SUB   = 5'd2,  OP_BSUB  = 5'd3;
    localparam logic [4:0] OP_NEG   = 5'd4,  OP_INC   = 5'd5,  OP_DEC   = 5'd6,  OP_PASS  = 5'd7;
    localparam logic [4:0] OP_AND   = 5'd8,  OP_OR    = 5'd9,  OP_XOR   = 5'd10, OP_COMP  = 5'd11;
    localparam logic [4:0] OP_LASL  = 5'd12, OP_RASR  = 5'd13, OP_LLSL  = 5'd14, OP_RLSR  = 5'd15;
    localparam logic [4:0] OP_LROT  = 5'd16, OP_RROT  = 5'd17, OP_LCROT = 5'd18, OP_RCROT = 5'd19;
    localparam logic [4:0] OP_MUL   = 5'd20;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     res_q, res_d, hi_q, hi_d;
    logic                 carry_q, carry_d, borrow_q, borrow_d, ovf_q, ovf_d;
    logic                 zero_q, zero_d, neg_q, neg_d, ill_q, ill_d;

    logic [WIDTH:0]       sum_w, dif_w;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c, alu_b, alu_v, alu_ill;
    logic                 a_s, b_s;
    logic [2*WIDTH-1:0]   acc_nxt;

    assign a_s = operand_A[WIDTH-1];
    assign b_s = operand_B[WIDTH-1];

    // Extra top bit of the WIDTH+1 sums is the unsigned carry / borrow.
    assign sum_w = {1'b0, operand_A} + {1'b0, operand_B}
                 + {{WIDTH{1'b0}}, (opcode == OP_CADD) & carry_in};
    assign dif_w = {1'b0, operand_A} - {1'b0, operand_B}
                 - {{WIDTH{1'b0}}, (opcode == OP_BSUB) & borrow_in};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        alu_res = '0;
        alu_c   = 1'b0;
        alu_b   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (opcode)
            OP_ADD, OP_CADD: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (a_s == b_s) && (alu_res[WIDTH-1] != a_s);
            end
            OP_SUB, OP_BSUB: begin
                alu_res = dif_w[WIDTH-1:0];
                alu_b   = dif_w[WIDTH];
                alu_v   = (a_s != b_s) && (alu_res[WIDTH-1] != a_s);
            end
            OP_NEG: begin
                alu_res = '0 - operand_A;
                alu_v   = (operand_A == MIN_VAL);
            end
            OP_INC: begin
                alu_res = operand_A + WIDTH'(1);
                alu_c   = &operand_A;
                alu_v   = (operand_A == MAX_VAL);
            end
            OP_DEC: begin
                alu_res = operand_A - WIDTH'(1);
                alu_b   = (operand_A == '0);
                alu_v   = (operand_A == MIN_VAL);
            end
            OP_PASS: alu_res = operand_A;
            OP_AND:  alu_res = operand_A & operand_B;
            OP_OR:   alu_res = operand_A | operand_B;
            OP_XOR:  alu_res = operand_A ^ operand_B;
            OP_COMP: alu_res = ~operand_A;
            OP_LASL, OP_LLSL: begin
                alu_res = {operand_A[WIDTH-2:0], 1'b0};
                alu_c   = operand_A[WIDTH-1];
                alu_v   = (opcode == OP_LASL) && (operand_A[WIDTH-1] ^ operand_A[WIDTH-2]);
            end
            OP_RASR: begin
                alu_res = {operand_A[WIDTH-1], operand_A[WIDTH-1:1]};
                alu_c   = operand_A[0];
            end
            OP_RLSR: begin
                alu_res = {1'b0, operand_A[WIDTH-1:1]};
                alu_c   = operand_A[0];
            end
            OP_LROT: begin
                alu_res = {operand_A[WIDTH-2:0], operand_A[WIDTH-1]};
                alu_c   = operand_A[WIDTH-1];
            end
            OP_RROT: begin
                alu_res = {operand_A[0], operand_A[WIDTH-1:1]};
                alu_c   = operand_A[0];
            end
            OP_LCROT: begin
                alu_res = {operand_A[WIDTH-2:0], carry_in};
                alu_c   = operand_A[WIDTH-1];
            end
            OP_RCROT: begin
                alu_res = {carry_in, operand_A[WIDTH-1:1]};
                alu_c   = operand_A[0];
            end
            OP_MUL: alu_ill = 1'b0;
            default: alu_ill = 1'b1;
        endcase
    end

    assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        hi_d     = hi_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ill_d    = ill_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (opcode == OP_MUL) begin
                        state_d  = S_MUL;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, operand_A};
                        mplier_d = operand_B;
                        cnt_d    = '0;
                    end else begin
                        state_d  = S_DONE;
                        res_d    = alu_res;
                        hi_d     = '0;
                        carry_d  = alu_c;
                        borrow_d = alu_b;
                        ovf_d    = alu_v;
                        zero_d   = (alu_res == '0);
                        neg_d    = alu_res[WIDTH-1];
                        ill_d    = alu_ill;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_nxt;
                mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d  = S_DONE;
                    res_d    = acc_nxt[WIDTH-1:0];
                    hi_d     = acc_nxt[2*WIDTH-1:WIDTH];
                    carry_d  = 1'b0;
                    borrow_d = 1'b0;
                    ovf_d    = (acc_nxt[2*WIDTH-1:WIDTH] != '0);
                    zero_d   = (acc_nxt[WIDTH-1:0] == '0);
                    neg_d    = acc_nxt[WIDTH-1];
                    ill_d    = 1'b0;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            hi_q     <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            hi_q     <= hi_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ill_q    <= ill_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign result_out = res_q;
    assign result_hi  = hi_q;
    assign carry_out  = carry_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;
    assign zero       = zero_q;
    assign negative   = neg_q;
    assign illegal    = ill_q;

endmodule
